display_scan_controller: RTL
============================

Name: display_scan_controller

Overview:
- Sequential front end for the 4-digit seven-segment display path.
- Generates the time-multiplexed active-low digit select that drives the segment_display `digit` input.
- Inserts an all-off guard interval between digits to prevent ghosting.
- Double-buffers the displayed value, sign and radix so that updates only take effect at frame boundaries (no tearing). Also provides frame-synchronous blinking.

Parameters:
- DIGIT_TICKS, 100000, clk cycles each digit is lit (≥2).
- GUARD_TICKS, 2000, clk cycles of all-off between consecutive digits (≥1).
- BLINK_FRAMES, 125, frames per blink half-period (≥1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- value_in  in  6  value to display
- negative_in  in  1  sign request
- is_dec_in  in  1  1 = decimal rendering, 0 = hex
- update  in  1  single-cycle strobe; captures value_in/negative_in/is_dec_in
- blink_en  in  1  enable blinking of the whole display
- digit_sel  out  4  active-low digit select, to segment_display digit
- display_value  out  6  active value, to segment_display display_value
- show_negative  out  1  active sign, to segment_display show_negative
- is_dec  out  1  active radix, to segment_display is_dec
- frame_start  out  1  one-cycle pulse on entry to digit 0 of each frame
- pending  out  1  captured update not yet applied

Behaviour:
- Reset and initial state:
  - Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
  - On rst_n low: digit_sel=4'b1111, display_value=0, show_negative=0, is_dec=0, frame_start=0, pending=0.
  - Also cleared on reset: prescaler, frame counter and blink phase (phase reset = visible).
  - After reset the FSM is in GUARD with next-digit index 0.
- FSM states: GUARD, D0, D1, D2, D3.
  - digit_sel in Dn = 4'b1110, 4'b1101, 4'b1011, 4'b0111 for n = 0..3.
  - digit_sel in GUARD = 4'b1111.
- Prescaler:
  - Loads 0 on every state entry and counts up by 1.
  - Dn exits when count == DIGIT_TICKS-1; GUARD exits when count == GUARD_TICKS-1.
  - Dn → GUARD; GUARD → D(next); next = (last+1) mod 4, so D3 wraps to D0.
  - Each digit is therefore lit exactly DIGIT_TICKS cycles; frame period = 4*(DIGIT_TICKS+GUARD_TICKS).
- Shadow/active registers:
  - update=1 writes the inputs into the shadow register and sets pending=1, in any state.
  - Repeated updates before application overwrite the shadow; last wins.
  - On the GUARD→D0 transition cycle, if pending=1: shadow→active and pending clears. The new outputs are visible in the first D0 cycle.
  - If update coincides with that transition cycle: the old shadow is applied, the new capture is stored, and pending stays 1 (applied next frame).
  - Worst-case update-to-display latency: one frame plus one cycle.
- frame_start: registered, high for exactly the first cycle of D0.
- Blink:
  - Frame counter increments on each frame_start and wraps at BLINK_FRAMES-1; the wrap toggles blink phase.
  - When blink_en=1 and phase=off, digit_sel is forced to 4'b1111. The FSM and counters keep running.
  - blink_en deassertion takes effect the next cycle.
  - blink_en=0 resets phase to visible and clears the frame counter.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset mid-frame: immediate return to reset values; pending capture is discarded.

Decomposition:
- Shared package display_pkg:
  - typedef scan_state_t {GUARD, D0, D1, D2, D3}.
  - Constants DIGIT_OFF = 4'b1111 and the DIGIT_SEL[0:3] one-cold codes.
  - Constant NUM_DIGITS = 4.
- One natural sub-module, scan_prescaler: parameterised terminal-count counter with a load input and a done output. Used for both the digit-on and guard intervals (terminal selected per state).
- A top-level wrapper instantiates display_scan_controller and segment_display; that wrapper is not part of this block.

Test Plan (DIGIT_TICKS=4, GUARD_TICKS=1, BLINK_FRAMES=2):
1. Reset release, no update → digit_sel sequence 1111 ×1, 1110 ×4, 1111 ×1, 1101 ×4, 1111, 1011 ×4, 1111, 0111 ×4, then repeats; frame period 20 cycles; frame_start pulses once per 20 cycles; display_value=0.
2. update with value_in=6'd42, negative_in=1, is_dec_in=1 mid-D1 → pending=1; outputs remain at 0/0/0 until the first D0 cycle; then 42/1/1 and pending=0.
3. Two updates (6'd5 then 6'd9) in the same frame → only 9 is ever applied; 5 never appears on display_value.
4. update on the GUARD→D0 transition cycle with value 6'd17, shadow previously 6'd3 → D0 shows 3; next frame shows 17; pending high across exactly one frame.
5. blink_en=1 → digit_sel = 1111 for frames 2–3, scanning for frames 4–5, and so on; frame_start continues every 20 cycles; blink_en=0 mid-off-phase → scanning resumes the next cycle.
6. rst_n pulsed low asynchronously (between clock edges) during D2 with pending=1 → digit_sel=1111 and pending=0 immediately; after release the sequence restarts from GUARD→D0.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment scan path.
package display_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [2:0] scan_state_t;
    localparam scan_state_t GUARD = 3'd0;
    localparam scan_state_t D0    = 3'd1;
    localparam scan_state_t D1    = 3'd2;
    localparam scan_state_t D2    = 3'd3;
    localparam scan_state_t D3    = 3'd4;

    localparam logic [3:0] DIGIT_OFF = 4'b1111;
    localparam logic [0:NUM_DIGITS-1][3:0] DIGIT_SEL = {4'b1110, 4'b1101, 4'b1011, 4'b0111};

    typedef struct packed {
        logic [5:0] value;
        logic       negative;
        logic       is_dec;
    } disp_t;

    function automatic scan_state_t digit_state(input logic [1:0] idx);
        scan_state_t s;
        s = D0;
        case (idx)
            2'd1:    s = D1;
            2'd2:    s = D2;
            2'd3:    s = D3;
            default: s = D0;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] sel_for(input scan_state_t s);
        logic [3:0] sel;
        sel = DIGIT_OFF;
        case (s)
            D0:      sel = DIGIT_SEL[0];
            D1:      sel = DIGIT_SEL[1];
            D2:      sel = DIGIT_SEL[2];
            D3:      sel = DIGIT_SEL[3];
            default: sel = DIGIT_OFF;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Terminal-count interval counter; restarts from zero whenever load is high.
module scan_prescaler #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] terminal,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    count <= '0;
        else if (load) count <= '0;
        else           count <= count + WIDTH'(1);
    end

    assign done = (count == terminal);

endmodule

// File: rtl/display_scan_controller.sv
// Digit scan FSM with guard gaps, frame-synchronous value update and blinking.
module display_scan_controller
    import display_pkg::*;
#(
    parameter int DIGIT_TICKS  = 100000,
    parameter int GUARD_TICKS  = 2000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] value_in,
    input  logic       negative_in,
    input  logic       is_dec_in,
    input  logic       update,
    input  logic       blink_en,
    output logic [3:0] digit_sel,
    output logic [5:0] display_value,
    output logic       show_negative,
    output logic       is_dec,
    output logic       frame_start,
    output logic       pending
);

    localparam int MAX_TICKS = (DIGIT_TICKS > GUARD_TICKS) ? DIGIT_TICKS : GUARD_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS);
    localparam int FCNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0]  DIGIT_TC = CNT_W'(DIGIT_TICKS - 1);
    localparam logic [CNT_W-1:0]  GUARD_TC = CNT_W'(GUARD_TICKS - 1);
    localparam logic [FCNT_W-1:0] BLINK_TC = FCNT_W'(BLINK_FRAMES - 1);

    scan_state_t       state, state_nx;
    logic [1:0]        next_idx, idx_nx;
    logic              tc_done, frame_tick;
    logic [FCNT_W-1:0] fcnt, fcnt_nx;
    logic              phase, phase_nx;
    disp_t             shadow, active;

    // Every interval end is also a state entry, so done doubles as the reload.
    scan_prescaler #(.WIDTH(CNT_W)) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tc_done),
        .terminal ((state == GUARD) ? GUARD_TC : DIGIT_TC),
        .done     (tc_done)
    );

    always_comb begin
        state_nx   = state;
        idx_nx     = next_idx;
        frame_tick = 1'b0;
        if (tc_done) begin
            if (state == GUARD) begin
                state_nx   = digit_state(next_idx);
                idx_nx     = next_idx + 2'd1;
                frame_tick = (next_idx == 2'd0);
            end else begin
                state_nx = GUARD;
            end
        end
    end

    // Phase flips together with D0 entry so a blink never splits a frame.
    always_comb begin
        fcnt_nx  = fcnt;
        phase_nx = phase;
        if (!blink_en) begin
            fcnt_nx  = '0;
            phase_nx = 1'b0;
        end else if (frame_tick) begin
            if (fcnt == BLINK_TC) begin
                fcnt_nx  = '0;
                phase_nx = ~phase;
            end else begin
                fcnt_nx = fcnt + FCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= GUARD;
            next_idx    <= 2'd0;
            fcnt        <= '0;
            phase       <= 1'b0;
            digit_sel   <= DIGIT_OFF;
            frame_start <= 1'b0;
            pending     <= 1'b0;
            shadow      <= '0;
            active      <= '0;
        end else begin
            state       <= state_nx;
            next_idx    <= idx_nx;
            fcnt        <= fcnt_nx;
            phase       <= phase_nx;
            digit_sel   <= phase_nx ? DIGIT_OFF : sel_for(state_nx);
            frame_start <= frame_tick;
            if (frame_tick && pending) active <= shadow;
            if (update) begin
                shadow.value    <= value_in;
                shadow.negative <= negative_in;
                shadow.is_dec   <= is_dec_in;
            end
            // A capture on the apply cycle survives into the next frame.
            pending <= update | (pending & ~frame_tick);
        end
    end

    assign display_value = active.value;
    assign show_negative = active.negative;
    assign is_dec        = active.is_dec;

endmodule
